// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: stall/flush FSM encoding and pipeline constants.
package cpu_pipe_pkg;

  localparam int          REG_AW_DEF = 3;
  localparam logic [15:0] NOP_INSN   = 16'h001F;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                    count <= '0;
    else if (inc && (~count != '0)) count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use stalls, branch flushes, memory wait and halt.
module pipe_hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int REG_AW       = REG_AW_DEF,
  parameter int CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              branch_taken,
  input  logic              mem_busy,
  input  logic              halt_req,
  input  logic              resume,
  output logic              pc_load,
  output logic              ifid_load,
  output logic              ifid_nop,
  output logic              idex_load,
  output logic              idex_nop,
  output logic              exmem_load,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

  state_t     state, state_nxt;
  logic [2:0] fcnt, fcnt_nxt;
  logic       hazard_lu, stall_inc, flush_inc;
  logic       pc_ld_c, ifid_ld_c, ifid_nop_c, idex_ld_c, idex_nop_c, exmem_ld_c;

  assign hazard_lu = ex_is_load & ((id_use_rs & (id_rs == ex_rd)) |
                                   (id_use_rt & (id_rt == ex_rd)));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    fcnt_nxt   = fcnt;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    pc_ld_c    = 1'b0;
    ifid_ld_c  = 1'b0;
    ifid_nop_c = 1'b0;
    idex_ld_c  = 1'b0;
    idex_nop_c = 1'b0;
    exmem_ld_c = 1'b0;
    // A memory wait freezes everything, including the FSM and counters.
    if (!mem_busy) begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            pc_ld_c    = 1'b1;
            ifid_nop_c = 1'b1;
            idex_nop_c = 1'b1;
            exmem_ld_c = 1'b1;
            flush_inc  = 1'b1;
            if (FLUSH_CYCLES > 0) begin
              state_nxt = FLUSH;
              fcnt_nxt  = FC;
            end
          end else if (halt_req) begin
            state_nxt = HALTED;
          end else if (hazard_lu) begin
            idex_nop_c = 1'b1;
            exmem_ld_c = 1'b1;
            stall_inc  = 1'b1;
          end else begin
            pc_ld_c    = 1'b1;
            ifid_ld_c  = 1'b1;
            idex_ld_c  = 1'b1;
            exmem_ld_c = 1'b1;
          end
        end
        FLUSH: begin
          pc_ld_c    = 1'b1;
          ifid_nop_c = 1'b1;
          idex_ld_c  = 1'b1;
          exmem_ld_c = 1'b1;
          fcnt_nxt   = fcnt - 1'b1;
          if (fcnt <= 3'd1) state_nxt = RUN;
        end
        HALTED: begin
          if (resume) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Controls are forced low while reset is held so the pipeline stays quiet.
  assign pc_load    = RSTN & pc_ld_c;
  assign ifid_load  = RSTN & ifid_ld_c;
  assign ifid_nop   = RSTN & ifid_nop_c;
  assign idex_load  = RSTN & idex_ld_c;
  assign idex_nop   = RSTN & idex_nop_c;
  assign exmem_load = RSTN & exmem_ld_c;
  assign halted     = RSTN & (state == HALTED);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .RSTN (RSTN),
    .inc  (stall_inc),
    .count(stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK  (CLK),
    .RSTN (RSTN),
    .inc  (flush_inc),
    .count(flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table plus flush/halt/saturation sequences.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 3;
  localparam int CNT_W  = 16;

  // {pc_load, ifid_load, ifid_nop, idex_load, idex_nop, exmem_load}
  localparam logic [5:0] O_NORM  = 6'b110101;
  localparam logic [5:0] O_STALL = 6'b000011;
  localparam logic [5:0] O_BR    = 6'b101011;
  localparam logic [5:0] O_FL    = 6'b101101;
  localparam logic [5:0] O_ZERO  = 6'b000000;

  logic              CLK = 1'b0;
  logic              RSTN;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
  logic              id_use_rs, id_use_rt, ex_is_load;
  logic              branch_taken, mem_busy, halt_req, resume;
  logic              pc_load, ifid_load, ifid_nop, idex_load, idex_nop, exmem_load, halted;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;
  int exp_stall = 0;

  typedef struct {
    logic [2:0] rs, rt, rd;
    logic       use_rs, use_rt, is_load, busy;
    logic [5:0] outs;
    int         inc;
  } vec_t;

  vec_t vecs[8];

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .halt_req(halt_req), .resume(resume),
    .pc_load(pc_load), .ifid_load(ifid_load), .ifid_nop(ifid_nop),
    .idex_load(idex_load), .idex_nop(idex_nop), .exmem_load(exmem_load),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [5:0] exp, input logic exp_h);
    #1;
    chk({name, ".ctl"}, 32'({pc_load, ifid_load, ifid_nop, idex_load, idex_nop, exmem_load}), 32'(exp));
    chk({name, ".halted"}, 32'(halted), 32'(exp_h));
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rd = '0; id_use_rs = 0; id_use_rt = 0; ex_is_load = 0;
    branch_taken = 0; mem_busy = 0; halt_req = 0; resume = 0;
  endtask

  task automatic set_hazard();
    id_rs = 3'd4; ex_rd = 3'd4; id_use_rs = 1; ex_is_load = 1;
  endtask

  initial begin
    vecs[0] = '{3'd3, 3'd0, 3'd3, 1, 0, 1, 0, O_STALL, 1};
    vecs[1] = '{3'd3, 3'd0, 3'd3, 0, 0, 1, 0, O_NORM,  0};
    vecs[2] = '{3'd1, 3'd5, 3'd5, 0, 1, 1, 0, O_STALL, 1};
    vecs[3] = '{3'd1, 3'd5, 3'd5, 0, 1, 0, 0, O_NORM,  0};
    vecs[4] = '{3'd2, 3'd6, 3'd3, 1, 1, 1, 0, O_NORM,  0};
    vecs[5] = '{3'd3, 3'd3, 3'd3, 1, 1, 1, 1, O_ZERO,  0};
    vecs[6] = '{3'd0, 3'd1, 3'd0, 1, 0, 1, 0, O_STALL, 1};
    vecs[7] = '{3'd2, 3'd7, 3'd7, 0, 1, 1, 0, O_STALL, 1};

    idle();
    RSTN = 0;
    chk_out("reset", O_ZERO, 0);
    chk("reset.stall", 32'(stall_cnt), 0);
    chk("reset.flush", 32'(flush_cnt), 0);
    #11 RSTN = 1;

    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("run_idle", O_NORM, 0);
    end
    chk("idle.stall", 32'(stall_cnt), 0);
    chk("idle.flush", 32'(flush_cnt), 0);

    for (int i = 0; i < 8; i++) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_rd = vecs[i].rd;
      id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt;
      ex_is_load = vecs[i].is_load; mem_busy = vecs[i].busy;
      chk_out($sformatf("vec%0d", i), vecs[i].outs, 0);
      tick();
      exp_stall += vecs[i].inc;
      chk($sformatf("vec%0d.stall", i), 32'(stall_cnt), 32'(exp_stall));
    end
    idle();

    // Branch with two extra flush cycles; hazard and branch ignored in FLUSH
    branch_taken = 1;
    chk_out("br.c0", O_BR, 0);
    tick();
    branch_taken = 1; set_hazard();
    chk_out("br.c1", O_FL, 0);
    chk("br.flush1", 32'(flush_cnt), 1);
    tick();
    idle();
    chk_out("br.c2", O_FL, 0);
    chk("br.flush_ign", 32'(flush_cnt), 1);
    chk("br.stall_ign", 32'(stall_cnt), 32'(exp_stall));
    tick();
    chk_out("br.c3", O_NORM, 0);

    // mem_busy freezes an in-progress flush
    tick();
    branch_taken = 1;
    chk_out("mb.br", O_BR, 0);
    tick();
    branch_taken = 0;
    chk_out("mb.fl1", O_FL, 0);
    tick();
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      branch_taken = (i == 1);
      chk_out("mb.busy", O_ZERO, 0);
      tick();
    end
    idle();
    chk("mb.flush", 32'(flush_cnt), 2);
    chk_out("mb.fl2", O_FL, 0);
    tick();
    chk_out("mb.run", O_NORM, 0);

    // Branch beats a simultaneous halt
    halt_req = 1; branch_taken = 1;
    chk_out("bh.br", O_BR, 0);
    tick();
    idle();
    chk_out("bh.fl1", O_FL, 0);
    tick();
    chk_out("bh.fl2", O_FL, 0);
    tick();
    chk_out("bh.run", O_NORM, 0);
    chk("bh.flush", 32'(flush_cnt), 3);

    // Halt alone, then resume
    halt_req = 1;
    chk_out("h.req", O_ZERO, 0);
    tick();
    chk_out("h.halted", O_ZERO, 1);
    tick();
    halt_req = 0;
    chk_out("h.hold", O_ZERO, 1);
    resume = 1;
    chk_out("h.resume", O_ZERO, 1);
    tick();
    resume = 0;
    chk_out("h.run", O_NORM, 0);

    // Stall counter saturation
    set_hazard();
    repeat (65540) @(posedge CLK);
    #1;
    chk("sat.stall", 32'(stall_cnt), 32'hFFFF);
    tick();
    chk("sat.stall_hold", 32'(stall_cnt), 32'hFFFF);
    idle();

    // Asynchronous reset in the middle of FLUSH
    branch_taken = 1;
    tick();
    branch_taken = 0;
    chk_out("rst.fl", O_FL, 0);
    #1 RSTN = 0;
    chk_out("rst.outs", O_ZERO, 0);
    chk("rst.stall", 32'(stall_cnt), 0);
    chk("rst.flush", 32'(flush_cnt), 0);
    #1 RSTN = 1;
    tick();
    chk_out("rst.run", O_NORM, 0);
    chk("rst.flush_after", 32'(flush_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
